// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: datapath widths, opcodes, ALU op
// encodings and the decoded-entry record.
package decode_stage_pkg;

  localparam int XMSB       = 31;
  localparam int ALU_OP_MSB = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [ALU_OP_MSB:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_MSB:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OP_MSB:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OP_MSB:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OP_MSB:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OP_MSB:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_MSB:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_MSB:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_OP_MSB:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_MSB:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [XMSB:0]       a;
    logic [XMSB:0]       b;
    logic [XMSB:0]       imm;
    logic [ALU_OP_MSB:0] op;
    logic                is_cond;
    logic [4:0]          rd;
    logic                rd_we;
    logic                illegal;
  } dec_s;

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational reads, one synchronous write,
// x0 hard-wired to zero, optional same-cycle write-back forwarding.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [4:0]    waddr_i,
  input  logic [XMSB:0] wdata_i,
  input  logic [4:0]    raddr_a_i,
  input  logic [4:0]    raddr_b_i,
  output logic [XMSB:0] rdata_a_o,
  output logic [XMSB:0] rdata_b_o
);

  logic [XMSB:0] mem_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0 && int'(waddr_i) < NREGS) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    if (raddr_a_i != 5'd0 && int'(raddr_a_i) < NREGS) rdata_a_o = mem_q[raddr_a_i];
    if (WB_BYPASS && we_i && waddr_i == raddr_a_i && raddr_a_i != 5'd0) rdata_a_o = wdata_i;
  end

  always_comb begin
    rdata_b_o = '0;
    if (raddr_b_i != 5'd0 && int'(raddr_b_i) < NREGS) rdata_b_o = mem_q[raddr_b_i];
    if (WB_BYPASS && we_i && waddr_i == raddr_b_i && raddr_b_i != 5'd0) rdata_b_o = wdata_i;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes one instruction into ALU operands/controls and holds
// it in a single-entry output register with a valid/ready handshake.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XMSB:0]       in_pc,
  input  logic                wb_we,
  input  logic [4:0]          wb_rd,
  input  logic [XMSB:0]       wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XMSB:0]       out_a,
  output logic [XMSB:0]       out_b,
  output logic [ALU_OP_MSB:0] out_op,
  output logic                out_is_cond,
  output logic [XMSB:0]       out_imm,
  output logic [4:0]          out_rd,
  output logic                out_rd_we,
  output logic                out_illegal
);

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [4:0]    rs1, rs2;
  logic [XMSB:0] rs1_data, rs2_data, imm_i, imm_u, imm_b;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

  decode_stage_regfile #(
    .NREGS     (NREGS),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .we_i      (wb_we),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rs1_data),
    .rdata_b_o (rs2_data)
  );

  // Illegal encodings leave every field but rd at its zero default.
  dec_s dec;
  always_comb begin
    dec    = '0;
    dec.rd = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.a     = rs1_data;
          dec.b     = rs2_data;
          dec.op    = {in_instr[30], funct3};
          dec.rd_we = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.a     = rs1_data;
        dec.b     = imm_i;
        dec.op    = {(funct3 == 3'b101) ? in_instr[30] : 1'b0, funct3};
        dec.rd_we = 1'b1;
      end
      OPC_LUI: begin
        dec.b     = imm_u;
        dec.op    = ALU_ADD;
        dec.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a     = in_pc;
        dec.b     = imm_u;
        dec.op    = ALU_ADD;
        dec.rd_we = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec.illegal = 1'b1;
        end else begin
          dec.a       = rs1_data;
          dec.b       = rs2_data;
          dec.op      = {1'b0, funct3};
          dec.is_cond = 1'b1;
          dec.imm     = imm_b;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  dec_s entry_q, entry_d;
  logic valid_q, valid_d, load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      entry_d = dec;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_a       = entry_q.a;
  assign out_b       = entry_q.b;
  assign out_op      = entry_q.op;
  assign out_is_cond = entry_q.is_cond;
  assign out_imm     = entry_q.imm;
  assign out_rd      = entry_q.rd;
  assign out_rd_we   = entry_q.rd_we;
  assign out_illegal = entry_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_imm;
  logic [3:0]  out_op;
  logic        out_is_cond, out_rd_we, out_illegal;
  logic [4:0]  out_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.NREGS(32), .WB_BYPASS(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_op      (out_op),
    .out_is_cond (out_is_cond),
    .out_imm     (out_imm),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    @(negedge clk);
    wb_we = 1'b1; wb_rd = rd; wb_data = data;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_op", {28'b0, out_op}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);

    // add x1,x1,x2 with latency check
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002080B3;
    #1;
    chk("add_pre_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_op", {28'b0, out_op}, 32'h0);
    chk("add_rd", {27'b0, out_rd}, 32'd1);
    chk("add_rd_we", {31'b0, out_rd_we}, 32'd1);
    chk("add_imm", out_imm, 32'd0);
    chk("add_illegal", {31'b0, out_illegal}, 32'd0);

    issue(32'hFFF00093, 32'h0);
    chk("addi_a", out_a, 32'd0);
    chk("addi_b", out_b, 32'hFFFFFFFF);
    chk("addi_op", {28'b0, out_op}, 32'h0);
    chk("addi_rd_we", {31'b0, out_rd_we}, 32'd1);

    issue(32'h4010D093, 32'h0);
    chk("srai_op", {28'b0, out_op}, 32'hD);
    chk("srai_a", out_a, 32'd5);
    chk("srai_b", out_b, 32'd1025);

    issue(32'h00208463, 32'h0);
    chk("beq_cond", {31'b0, out_is_cond}, 32'd1);
    chk("beq_op", {28'b0, out_op}, 32'h0);
    chk("beq_imm", out_imm, 32'd8);
    chk("beq_rd_we", {31'b0, out_rd_we}, 32'd0);
    chk("beq_a", out_a, 32'd5);
    chk("beq_b", out_b, 32'd7);

    issue(32'h0020A463, 32'h0);
    chk("br010_illegal", {31'b0, out_illegal}, 32'd1);
    chk("br010_cond", {31'b0, out_is_cond}, 32'd0);
    chk("br010_a", out_a, 32'd0);
    chk("br010_b", out_b, 32'd0);
    chk("br010_imm", out_imm, 32'd0);

    issue(32'h402080B3, 32'h0);
    chk("sub_op", {28'b0, out_op}, 32'h8);
    chk("sub_illegal", {31'b0, out_illegal}, 32'd0);

    issue(32'h022080B3, 32'h0);
    chk("f7bad_illegal", {31'b0, out_illegal}, 32'd1);
    chk("f7bad_rd_we", {31'b0, out_rd_we}, 32'd0);

    issue(32'h402090B3, 32'h0);
    chk("sll30_illegal", {31'b0, out_illegal}, 32'd1);
    chk("sll30_op", {28'b0, out_op}, 32'h0);

    issue(32'h0000007F, 32'h0);
    chk("badopc_illegal", {31'b0, out_illegal}, 32'd1);

    issue(32'h123450B7, 32'h0);
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_rd_we", {31'b0, out_rd_we}, 32'd1);

    issue(32'h12345097, 32'h100);
    chk("auipc_a", out_a, 32'h100);
    chk("auipc_b", out_b, 32'h12345000);
    chk("auipc_op", {28'b0, out_op}, 32'h0);

    // same-cycle write-back forwarding of x3, and x0 write ignored
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00018233; out_ready = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    @(posedge clk);
    #1;
    in_valid = 1'b0; wb_we = 1'b0;
    chk("bypass_a", out_a, 32'h1234);
    chk("bypass_b", out_b, 32'd0);

    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h000002B3;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    @(posedge clk);
    #1;
    in_valid = 1'b0; wb_we = 1'b0;
    chk("x0_bypass_a", out_a, 32'd0);

    issue(32'h000002B3, 32'h0);
    chk("x0_stored_a", out_a, 32'd0);
    issue(32'h00018233, 32'h0);
    chk("x3_stored_a", out_a, 32'h1234);

    // backpressure for 5 cycles, then release
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002080B3;
    @(posedge clk);
    #1;
    chk("stall_load_a", out_a, 32'd5);
    @(negedge clk);
    in_instr = 32'h402080B3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_a", out_a, 32'd5);
      chk("stall_op", {28'b0, out_op}, 32'h0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("release_sub_op", {28'b0, out_op}, 32'h8);
    chk("release_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    in_instr = 32'hFFF00093;
    @(posedge clk);
    #1;
    chk("release_addi_b", out_b, 32'hFFFFFFFF);
    chk("release_addi_op", {28'b0, out_op}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("release_empty", {31'b0, out_valid}, 32'd0);

    // flush with incoming transfer, then flush of a held entry
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002080B3; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("flush_in_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_held_load", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_held_clear", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;

    // reset pulse while stalled
    in_valid = 1'b1; in_instr = 32'h002080B3; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("prerst_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_a", out_a, 32'd0);
    chk("midrst_b", out_b, 32'd0);
    chk("midrst_op", {28'b0, out_op}, 32'h0);
    chk("midrst_rd", {27'b0, out_rd}, 32'd0);
    chk("midrst_rd_we", {31'b0, out_rd_we}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    issue(32'h002080B3, 32'h0);
    chk("postrst_rf_a", out_a, 32'd0);
    chk("postrst_rf_b", out_b, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers (x0 reads as zero).
REQ-002 SHALL have parameter WB_BYPASS, default 1, meaning write-back data is forwarded to same-cycle register reads.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input XMSB+1: the fetch-side handshake.
REQ-006 SHALL have ports wb_we input 1, wb_rd input 5, wb_data input XMSB+1: the register write port.
REQ-007 SHALL have port flush input 1, which discards held and incoming instructions.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: the execute-side handshake.
REQ-009 SHALL have ports out_a and out_b, output, XMSB+1 each: ALU operands.
REQ-010 SHALL have ports out_op output ALU_OP_MSB+1 and out_is_cond output 1: ALU controls.
REQ-011 SHALL have ports out_imm output XMSB+1 (branch offset), out_rd output 5, out_rd_we output 1 and out_illegal output 1.

Function
REQ-012 SHALL hold one output entry; in_ready = !out_valid || out_ready, combinationally.
REQ-013 SHALL load the entry on the clk edge where in_valid && in_ready && !flush; out_valid becomes 1 in the next cycle (latency 1).
REQ-014 SHALL clear out_valid when out_ready && out_valid and no new transfer occurs; simultaneous drain and load keeps out_valid=1 with the new entry.
REQ-015 SHALL keep all out_* stable while out_valid && !out_ready.
REQ-016 SHALL, on flush, clear out_valid next edge; an in_valid transfer in the same cycle is accepted (in_ready per REQ-012) and discarded.
REQ-017 SHALL decode OP (0110011): a=rs1, b=rs2, op={instr[30],funct3}, rd_we=1, is_cond=0.
REQ-018 SHALL decode OP-IMM (0010011): a=rs1, b=sext immI, op={funct3==101 ? instr[30] : 0, funct3}, rd_we=1.
REQ-019 SHALL decode LUI: a=0, b=immU; AUIPC: a=in_pc, b=immU; both op=ADD (0000), rd_we=1.
REQ-020 SHALL decode BRANCH (1100011): a=rs1, b=rs2, op={0,funct3}, is_cond=1, rd_we=0, out_imm=sext immB.
REQ-021 SHALL flag out_illegal=1 and force rd_we=0, a=b=0, op=0, is_cond=0 for: other opcodes; BRANCH funct3 010/011; OP funct7 other than 0000000/0100000; instr[30]=1 with OP funct3 not 000/101.
REQ-022 SHALL set out_imm=0 for non-branch instructions.
REQ-023 SHALL return 0 for any read of x0 and ignore writes to x0.
REQ-024 SHALL, when WB_BYPASS=1, return wb_data for a read of rs when wb_we && wb_rd==rs && rs!=0 in the same cycle.
REQ-025 SHALL, when WB_BYPASS=0, return the previously stored value for such reads.
REQ-026 SHALL perform register writes regardless of in/out handshake state and of flush.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force out_valid=0, out_a=out_b=out_imm=0, out_op=0, out_is_cond=0, out_rd=0, out_rd_we=0 and out_illegal=0.
REQ-028 SHALL reset all register file contents to 0.
REQ-029 SHALL drop an entry held when reset asserts mid-operation; in_ready=1 at the first edge after release.

Structure
REQ-030 SHALL take opcode constants, ALU op encodings (ADD=0000, SUB=1000, ...), XMSB and ALU_OP_MSB from the shared defs header; none are redefined locally.
REQ-031 SHALL instantiate one sub-module regfile: NREGS x (XMSB+1) storage with two combinational read ports, one synchronous write port and async reset.

Verification
REQ-032 SHALL cover: write x1=5 and x2=7, then instr 0x002080B3 (add x1,x1,x2) -> out_a=5, out_b=7, out_op=0000, out_rd=1, out_rd_we=1, out_valid one cycle later.
REQ-033 SHALL cover: 0xFFF00093 (addi x1,x0,-1) -> out_a=0, out_b=0xFFFFFFFF, op=0000; 0x4010D093 (srai x1,x1,1) -> op=1101.
REQ-034 SHALL cover: 0x00208463 (beq x1,x2,+8) -> is_cond=1, op=0000, out_imm=8, rd_we=0; funct3=010 variant -> out_illegal=1.
REQ-035 SHALL cover: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs unchanged; release -> one transfer per cycle, no loss or duplication.
REQ-036 SHALL cover: wb_we=1, wb_rd=3, wb_data=0x1234 in the same cycle as a read of x3 -> out_a=0x1234 (WB_BYPASS=1); writes to x0 -> reads stay 0.
REQ-037 SHALL cover: flush with in_valid=1 -> out_valid=0 next cycle; rst_n pulse mid-stall -> all outputs 0 immediately, in_ready=1 after release.
